// File: rtl/label_fetch_arb_pkg.sv
// label_fetch_arb_pkg
//   Shared constants, FSM state encoding and the round-robin pointer helper
//   for the label fetch arbiter and its round-robin sub-block.
//   Contents:
//     LABEL_NUM / LABEL_LEN / CHAR_W : label table geometry defaults
//     ASCII_SPACE                     : padding character skipped by trimming
//     state_t                         : IDLE / SEND / DONE
//     rr_next()                       : successor of a requester index mod n
package label_fetch_arb_pkg;

  localparam int LABEL_NUM = 16;
  localparam int LABEL_LEN = 8;
  localparam int CHAR_W    = 8;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Next round-robin start position after requester id has been served.
  function automatic logic [2:0] rr_next(input logic [2:0] id, input int n);
    if (int'(id) + 1 >= n) return 3'd0;
    return id + 3'd1;
  endfunction

endpackage

// File: rtl/label_fetch_arb_rr_arb.sv
// label_rr_arb
//   Combinational round-robin search over the request vector, starting at
//   rr_ptr and wrapping mod N_REQ. The first set bit found wins.
//   Ports:
//     req         in  N_REQ  request vector
//     rr_ptr      in  ID_W   search start position (always < N_REQ)
//     grant_valid out 1      at least one request is set
//     grant_id    out ID_W   index of the winning requester
module label_rr_arb
  import label_fetch_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_id
);

  // Scan from the farthest offset down to offset 0 so that the nearest set
  // bit to rr_ptr is the last one written and therefore wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % N_REQ]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/label_fetch_arb.sv
// label_fetch_arb
//   Shares one packed label string table among N_REQ overlay requesters.
//   A round-robin winner is granted from IDLE, its label index is latched,
//   the label's characters are streamed one per valid/ready handshake, and a
//   one-cycle ack pulse is returned to the served requester.
//
//   Optional build macro: LABEL_TRIM_EN
//     When defined, trailing spaces of the granted label are not sent; an
//     all-space label goes straight from the grant to the ack cycle.
//
//   Ports:
//     i_clk        in  1                          pixel-domain clock
//     i_rst        in  1                          async active-high reset
//     i_str        in  N_LABEL*LABEL_LEN*CHAR_W   packed table, label 0 in MSBs
//     i_req        in  N_REQ                      requests, held until ack
//     i_label      in  N_REQ*4                    label index per requester
//     o_ack        out N_REQ                      one-cycle done pulse
//     o_chr_valid  out 1                          char stream valid
//     i_chr_ready  in  1                          downstream ready
//     o_chr        out CHAR_W                     ASCII code
//     o_chr_pos    out 3                          char position in label
//     o_chr_id     out 3                          requester being served
//     o_chr_last   out 1                          final char of this label
//     o_busy       out 1                          FSM not idle
module label_fetch_arb
  import label_fetch_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int N_LABEL   = label_fetch_arb_pkg::LABEL_NUM,
  parameter int LABEL_LEN = label_fetch_arb_pkg::LABEL_LEN,
  parameter int CHAR_W    = label_fetch_arb_pkg::CHAR_W
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [N_LABEL*LABEL_LEN*CHAR_W-1:0] i_str,
  input  logic [N_REQ-1:0]                    i_req,
  input  logic [N_REQ*4-1:0]                  i_label,
  output logic [N_REQ-1:0]                    o_ack,
  output logic                                o_chr_valid,
  input  logic                                i_chr_ready,
  output logic [CHAR_W-1:0]                   o_chr,
  output logic [2:0]                          o_chr_pos,
  output logic [2:0]                          o_chr_id,
  output logic                                o_chr_last,
  output logic                                o_busy
);

  localparam int ID_W  = 3;
  localparam int POS_W = 3;
  localparam int IDX_W = 4;
  localparam int LBL_W = LABEL_LEN * CHAR_W;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    win_id;
  logic [POS_W-1:0]   pos;
  logic [IDX_W-1:0]   lbl_idx;
  logic [POS_W-1:0]   last_pos;

  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic [IDX_W-1:0]   grant_idx;
  logic [POS_W-1:0]   grant_last;
  logic               grant_empty;

  logic               send;
  logic [LBL_W-1:0]   cur_word;
  logic [CHAR_W-1:0]  cur_chr;

  // Label k sits at the (N_LABEL-1-k)-th slot counting from the LSB end.
  function automatic logic [LBL_W-1:0] label_word(
    input logic [N_LABEL*LBL_W-1:0] tbl,
    input logic [IDX_W-1:0]         idx
  );
    return tbl[(N_LABEL - 1 - int'(idx)) * LBL_W +: LBL_W];
  endfunction

  // Out-of-table indices fall back to label 0.
  function automatic logic [IDX_W-1:0] clamp_idx(input logic [IDX_W-1:0] raw);
    return (int'(raw) >= N_LABEL) ? '0 : raw;
  endfunction

`ifdef LABEL_TRIM_EN
  // Returns {empty, last}: last is the rightmost non-space position, empty
  // flags an all-space label.
  function automatic logic [POS_W:0] trim_scan(input logic [LBL_W-1:0] w);
    logic             empty;
    logic [POS_W-1:0] last;
    empty = 1'b1;
    last  = '0;
    for (int j = 0; j < LABEL_LEN; j++) begin
      if (w[(LABEL_LEN - 1 - j) * CHAR_W +: CHAR_W] != CHAR_W'(ASCII_SPACE)) begin
        empty = 1'b0;
        last  = POS_W'(j);
      end
    end
    return {empty, last};
  endfunction
`endif

  label_rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arb (
    .req         (i_req),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Grant-side decode: label selection and stream length of the winner.
`ifdef LABEL_TRIM_EN
  logic [LBL_W-1:0] grant_word;

  always_comb begin
    grant_idx                 = clamp_idx(i_label[int'(grant_id) * IDX_W +: IDX_W]);
    grant_word                = label_word(i_str, grant_idx);
    {grant_empty, grant_last} = trim_scan(grant_word);
  end
`else
  always_comb begin
    grant_idx   = clamp_idx(i_label[int'(grant_id) * IDX_W +: IDX_W]);
    grant_empty = 1'b0;
    grant_last  = POS_W'(LABEL_LEN - 1);
  end
`endif

  // Control: FSM, round-robin pointer, served requester and char position.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      win_id <= '0;
      pos    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            win_id <= grant_id;
            pos    <= '0;
            state  <= grant_empty ? ST_DONE : ST_SEND;
          end
        end
        ST_SEND: begin
          if (i_chr_ready) begin
            if (pos == last_pos) state <= ST_DONE;
            else                 pos   <= pos + POS_W'(1);
          end
        end
        ST_DONE: begin
          rr_ptr <= rr_next(win_id, N_REQ);
          pos    <= '0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Grant capture: label index and stream length are frozen for the whole
  // transfer, so later i_label edits are ignored until IDLE.
  always_ff @(posedge i_clk) begin
    if (state == ST_IDLE && grant_valid) begin
      lbl_idx  <= grant_idx;
      last_pos <= grant_last;
    end
  end

  // Stream outputs are forced to zero outside SEND so reset and idle read 0.
  assign send     = (state == ST_SEND);
  assign cur_word = label_word(i_str, lbl_idx);
  assign cur_chr  = cur_word[(LABEL_LEN - 1 - int'(pos)) * CHAR_W +: CHAR_W];

  assign o_chr_valid = send;
  assign o_chr       = send ? cur_chr : '0;
  assign o_chr_pos   = send ? pos : '0;
  assign o_chr_id    = send ? win_id : '0;
  assign o_chr_last  = send && (pos == last_pos);
  assign o_busy      = (state != ST_IDLE);
  assign o_ack       = (state == ST_DONE) ? (N_REQ'(1) << win_id) : '0;

endmodule

// File: tb/tb_label_fetch_arb.sv
// tb_label_fetch_arb
//   Directed bench for label_fetch_arb. A queue-based model predicts, per
//   cycle, the expected char stream, ack pulse and busy flag; literal
//   expectations pin the strings, latencies and service order.
module tb_label_fetch_arb;

  localparam int N_REQ = 4;
`ifdef LABEL_TRIM_EN
  localparam bit TRIM = 1'b1;
`else
  localparam bit TRIM = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [1023:0]        str;
  logic [N_REQ-1:0]     req = '0;
  logic [N_REQ*4-1:0]   label = '0;
  logic [N_REQ-1:0]     ack;
  logic                 valid;
  logic                 ready = 1'b1;
  logic [7:0]           chr;
  logic [2:0]           pos;
  logic [2:0]           id;
  logic                 last;
  logic                 busy;

  label_fetch_arb #(.N_REQ(N_REQ)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_str       (str),
    .i_req       (req),
    .i_label     (label),
    .o_ack       (ack),
    .o_chr_valid (valid),
    .i_chr_ready (ready),
    .o_chr       (chr),
    .o_chr_pos   (pos),
    .o_chr_id    (id),
    .o_chr_last  (last),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  logic [63:0] tbl [16];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ack_cyc = 0;
  int t0      = 0;

  logic [7:0] sent_c [$];
  int         sent_p [$];
  int         served [$];

  typedef struct {
    logic [7:0] c;
    int         p;
    bit         l;
  } ev_t;

  ev_t m_q [$];
  bit  m_job = 0;
  bit  m_ack = 0;
  int  m_id  = 0;
  int  m_rr  = 0;

  bit         stall_prev = 0;
  logic [7:0] prev_c;
  logic [2:0] prev_p;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected characters of label k: all of them, or up to the last non-space.
  function automatic void build(input int k);
    int n;
    n = 8;
    if (TRIM) begin
      n = 0;
      for (int j = 0; j < 8; j++)
        if (tbl[k][(7 - j) * 8 +: 8] != 8'h20) n = j + 1;
    end
    m_q.delete();
    for (int j = 0; j < n; j++)
      m_q.push_back('{c: tbl[k][(7 - j) * 8 +: 8], p: j, l: (j == n - 1)});
  endfunction

  // Model advance and handshake log on each rising edge (pre-edge values).
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst === 1'b0 && valid && ready) begin
        sent_c.push_back(chr);
        sent_p.push_back(int'(pos));
      end
      stall_prev = valid && !ready;
      prev_c     = chr;
      prev_p     = pos;
      if (rst !== 1'b0) begin
        m_q.delete();
        m_job = 0;
        m_ack = 0;
        m_rr  = 0;
      end else if (m_ack) begin
        m_ack = 0;
        m_job = 0;
        m_rr  = (m_id + 1) % N_REQ;
      end else if (m_job) begin
        if (ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_ack = 1;
        end
      end else begin
        bit found;
        found = 0;
        for (int k = 0; k < N_REQ; k++) begin
          int r;
          r = (m_rr + k) % N_REQ;
          if (!found && req[r]) begin
            found = 1;
            m_id  = r;
            m_job = 1;
            build(int'(label[r * 4 +: 4]));
            if (m_q.size() == 0) m_ack = 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        check("valid", valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
          check("chr",  chr,  m_q[0].c);
          check("pos",  pos,  m_q[0].p);
          check("last", last, m_q[0].l);
          check("id",   id,   m_id);
        end
        check("ack",  ack,  m_ack ? (4'b1 << m_id) : 4'b0);
        check("busy", busy, m_job);
        if (stall_prev && valid) begin
          check("hold_chr", chr, prev_c);
          check("hold_pos", pos, prev_p);
        end
      end
    end
  end

  // One cycle of the requester side: drop i_req of an acked requester.
  task automatic tick();
    @(negedge clk);
    #1;
    for (int r = 0; r < N_REQ; r++) begin
      if (ack[r] === 1'b1) begin
        req[r] = 1'b0;
        served.push_back(r);
        ack_cyc = cyc;
      end
    end
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (req == '0 && !busy) begin
        ok = 1;
        break;
      end
    end
    check("done_in_budget", ok, 1);
  endtask

  task automatic clear_logs();
    sent_c.delete();
    sent_p.delete();
    served.delete();
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [63:0] sent_str();
    logic [63:0] s;
    s = '0;
    foreach (sent_c[i]) s = {s[55:0], sent_c[i]};
    return s;
  endfunction

  function automatic int served_code();
    int v;
    v = 0;
    foreach (served[i]) v = v * 10 + served[i] + 1;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] e_str;
    bit          seen;
    int          nsv;

    tbl[0] = "        ";
    tbl[1] = "Pie     ";
    tbl[2] = "AB CD   ";
    tbl[3] = "Rect3   ";
    tbl[4] = "Zed 4567";
    tbl[5] = "Lbl5    ";
    tbl[6] = "    Tang";
    for (int k = 7; k < 16; k++) tbl[k] = "Filler  ";
    for (int k = 0; k < 16; k++) str[(15 - k) * 64 +: 64] = tbl[k];

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_ack",   ack,   0);
    check("rst_busy",  busy,  0);
    check("rst_chr",   chr,   0);
    check("rst_pos",   pos,   0);
    check("rst_id",    id,    0);
    check("rst_last",  last,  0);
    tick();
    rst = 1'b0;
    tick();

    // Single request, label 1; a later label change must be ignored
    clear_logs();
    tick();
    label[3:0] = 4'd1;
    req[0]     = 1'b1;
    t0         = cyc;
    tick();
    tick();
    label[3:0] = 4'd2;
    wait_done(40);
    e_str = TRIM ? 64'("Pie") : 64'("Pie     ");
    check("pie_str", sent_str(), e_str);
    check("pie_cnt", sent_c.size(), TRIM ? 3 : 8);
    check("pie_lat", ack_cyc - t0, TRIM ? 4 : 9);
    check("pie_served", served_code(), 1);

    // Blank label 0
    clear_logs();
    tick();
    label[3:0] = 4'd0;
    req[0]     = 1'b1;
    t0         = cyc;
    wait_done(40);
    e_str = TRIM ? 64'd0 : 64'("        ");
    check("blank_str", sent_str(), e_str);
    check("blank_cnt", sent_c.size(), TRIM ? 0 : 8);
    check("blank_lat", ack_cyc - t0, TRIM ? 1 : 9);

    // Backpressure on label 6, ready toggling every cycle
    clear_logs();
    tick();
    label[3:0] = 4'd6;
    req[0]     = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      ready = ~ready;
      if (req == '0 && !busy) begin
        seen = 1;
        break;
      end
    end
    ready = 1'b1;
    check("bp_done", seen, 1);
    check("bp_str", sent_str(), 64'("    Tang"));
    check("bp_cnt", sent_c.size(), 8);
    check("bp_last_pos", (sent_p.size() > 0) ? sent_p[sent_p.size() - 1] : -1, 7);

    // Arbitration from rr_ptr=0: all four at once, then 3 and 0 together
    do_reset();
    clear_logs();
    tick();
    label = {4'd4, 4'd3, 4'd2, 4'd1};
    req   = 4'hF;
    wait_done(120);
    check("arb_order", served_code(), 1234);
    check("arb_cnt", sent_c.size(), TRIM ? 21 : 32);
    clear_logs();
    tick();
    req[3] = 1'b1;
    req[0] = 1'b1;
    wait_done(60);
    check("arb_order2", served_code(), 14);

    // Move rr_ptr to 2, then reset in the middle of a stream at pos 3
    clear_logs();
    tick();
    req[1] = 1'b1;
    wait_done(40);
    check("pre_rst_served", served_code(), 2);
    clear_logs();
    tick();
    label[11:8] = 4'd4;
    req[2]      = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid && pos == 3'd3) begin
        seen = 1;
        break;
      end
    end
    check("reach_pos3", seen, 1);
    rst = 1'b1;
    req = '0;
    #1;
    check("mid_rst_valid", valid, 0);
    check("mid_rst_chr",   chr,   0);
    check("mid_rst_pos",   pos,   0);
    check("mid_rst_id",    id,    0);
    check("mid_rst_busy",  busy,  0);
    check("mid_rst_ack",   ack,   0);
    nsv = served.size();
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("mid_rst_no_ack", served.size(), nsv);

    // rr_ptr back at 0: requester 1 precedes 3; stream restarts at pos 0
    clear_logs();
    tick();
    label[7:4]   = 4'd3;
    label[15:12] = 4'd1;
    req[1]       = 1'b1;
    req[3]       = 1'b1;
    wait_done(60);
    check("post_rst_order", served_code(), 24);
    check("post_rst_pos0", (sent_p.size() > 0) ? sent_p[0] : -1, 0);
    check("post_rst_chr0", (sent_c.size() > 0) ? sent_c[0] : 8'h00, 8'h52);
    check("post_rst_cnt", sent_c.size(), TRIM ? 8 : 16);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/label_fetch_arb.md
Name: label_fetch_arb

Overview:
- Shares the single 16-entry label string table (16 labels × 8 ASCII chars, packed 1024-bit bus) among N_REQ rectangle-overlay requesters.
- Round-robin arbitrates requests, latches the winner's label index, then streams that label's characters one per handshake to the glyph renderer.
- Pulses a per-requester ack when the label is finished.
- Sits between the rect/ASCII overlay engines and the font/glyph ROM stage in the post-processing path.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- N_LABEL, 16, labels in table.
- LABEL_LEN, 8, chars per label.
- CHAR_W, 8, bits per char.

Ports:
- i_clk  in  1  pixel-domain clock.
- i_rst  in  1  asynchronous active-high reset.
- i_str  in  N_LABEL*LABEL_LEN*CHAR_W  packed label table.
  - Label k = i_str[(N_LABEL-1-k)*64 +: 64].
  - Char j (0 = leftmost) = byte [(7-j)*8 +: 8] of that label.
- i_req  in  N_REQ  per-requester request, held until ack.
- i_label  in  N_REQ*4  per-requester label index; requester r uses [r*4 +: 4].
- o_ack  out  N_REQ  one-cycle done pulse to the served requester.
- o_chr_valid  out  1  char stream valid.
- i_chr_ready  in  1  downstream ready.
- o_chr  out  CHAR_W  ASCII code.
- o_chr_pos  out  3  char position 0..7.
- o_chr_id  out  3  requester index being served.
- o_chr_last  out  1  final char of this label.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE, rr_ptr=0, pos=0.
  - All outputs 0.
  - Any in-flight label is abandoned with no ack.
- IDLE, arbitration:
  - If any i_req bit is set, the winner is the first set bit searching rr_ptr, rr_ptr+1, … mod N_REQ.
  - At the next edge, latch win_id, label=i_label[win_id], pos=0; go to SEND.
  - Latency: req sampled at edge N → o_chr_valid=1 in cycle N+1.
- SEND:
  - o_chr_valid=1; o_chr = char[pos] of the latched label.
  - o_chr_last = (pos == last_pos).
  - On valid & ready: if last, go to DONE; else pos+1.
  - While ready=0, all stream outputs are held stable.
- DONE:
  - o_ack[win_id]=1 for exactly one cycle.
  - rr_ptr = (win_id+1) mod N_REQ.
  - Next state IDLE.
  - The requester deasserts i_req on the edge ending DONE. IDLE never re-grants the same request.
- Back-to-back: minimum one IDLE cycle between labels.
- Full label cost, ready held high: 1 grant + 8 SEND + 1 DONE.
- Changes on i_label or i_req after the grant are ignored until IDLE.
- i_label values ≥ N_LABEL (only when N_LABEL<16) are treated as label 0.
- A requester dropping i_req mid-SEND does not abort the stream; ack is still issued.
- last_pos is LABEL_LEN-1 when the optional feature is off.

Optional Feature:
- Macro: LABEL_TRIM_EN.
- Defined:
  - At grant, compute last_pos = index of the rightmost non-space char (space = 8'h20).
  - Trailing spaces are not sent.
  - An all-space label goes IDLE→DONE directly (zero chars, ack one cycle after grant).
- Undefined: always LABEL_LEN chars, spaces included.

Decomposition:
- Shared define/package constants:
  - LABEL_NUM=16, LABEL_LEN=8, CHAR_W=8, ASCII_SPACE=8'h20.
  - State encodings IDLE/SEND/DONE.
- Sub-module label_rr_arb: combinational round-robin search from rr_ptr over i_req. Outputs grant_valid and grant_id.
- The parent owns rr_ptr and the FSM.

Test Plan:
- Single request, feature off: req0 with label 1 ("Pie     "), ready=1.
  - Required: 'P','i','e' then five 8'h20 at pos 0..7.
  - last at pos 7; o_ack[0] in the cycle after the last handshake; 10 cycles total.
- Same stimulus with LABEL_TRIM_EN.
  - Required: 'P','i','e' at pos 0..2, last on 'e', then ack.
- Blank label: label 0 with LABEL_TRIM_EN.
  - Required: no o_chr_valid; ack 1 cycle after grant.
  - Feature off: eight 8'h20.
- Backpressure: label 6 ("Tang"), ready alternating 1/0.
  - Required: o_chr/o_chr_pos stable during ready=0.
  - Each char sent exactly once; ack after 'g'/pos 7.
- Arbitration: all 4 requests asserted at once with rr_ptr=0.
  - Required: served order 0,1,2,3.
  - Then reassert req 3 and req 0 together → 0 served before 3 (rr_ptr=0 after serving 3).
- Reset mid-SEND at pos 3.
  - Required: all outputs 0 immediately; no ack; rr_ptr=0.
  - A subsequent request restarts at pos 0.
